// File: rtl/router_pkg.sv
// Shared router definitions: default byte width, the reserved address and the
// FSM state encodings used by the router FSM, this register stage and the bench.
package router_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;

  // Address 3 has no output FIFO and is never captured as a header.
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    StDecodeAddress,
    StLoadFirstData,
    StLoadData,
    StFifoFullState,
    StLoadAfterFull,
    StLoadParity,
    StCheckParityError,
    StWaitTillEmpty
  } state_e;

  function automatic logic addr_valid(input logic [1:0] addr);
    return addr != ADDR_INVALID;
  endfunction

endpackage

// File: rtl/router_reg_if.sv
// Signal bundle between the router FSM/source side and the datapath register stage.
interface router_reg_if #(
  parameter int unsigned DATA_WIDTH = router_pkg::DATA_WIDTH_DEF
);

  logic                  pkt_valid;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  fifo_full;
  logic                  detect_add;
  logic                  lfd_state;
  logic                  ld_state;
  logic                  full_state;
  logic                  laf_state;
  logic                  rst_int_reg;
  logic [DATA_WIDTH-1:0] dout;
  logic                  parity_done;
  logic                  low_pkt_valid;
  logic                  err;

  modport master (
    output pkt_valid,
    output data_in,
    output fifo_full,
    output detect_add,
    output lfd_state,
    output ld_state,
    output full_state,
    output laf_state,
    output rst_int_reg,
    input  dout,
    input  parity_done,
    input  low_pkt_valid,
    input  err
  );

  modport slave (
    input  pkt_valid,
    input  data_in,
    input  fifo_full,
    input  detect_add,
    input  lfd_state,
    input  ld_state,
    input  full_state,
    input  laf_state,
    input  rst_int_reg,
    output dout,
    output parity_done,
    output low_pkt_valid,
    output err
  );

endinterface

// File: rtl/router_parity_acc.sv
// Running XOR parity over header and payload, capture of the received parity
// byte, and the one-shot compare that produces err.
module router_parity_acc
  import router_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  clear,
  input  logic                  fold_en,
  input  logic [DATA_WIDTH-1:0] fold_data,
  input  logic                  pkt_load,
  input  logic [DATA_WIDTH-1:0] pkt_data,
  input  logic                  parity_done,
  input  logic                  err_clear,
  output logic                  err
);

  logic [DATA_WIDTH-1:0] int_parity_q, int_parity_d;
  logic [DATA_WIDTH-1:0] pkt_parity_q, pkt_parity_d;
  logic                  done_seen_q;
  logic                  err_q, err_d;

  always_comb begin
    int_parity_d = int_parity_q;
    if (clear) begin
      int_parity_d = '0;
    end else if (fold_en) begin
      int_parity_d = int_parity_q ^ fold_data;
    end
  end

  always_comb begin
    pkt_parity_d = pkt_parity_q;
    if (pkt_load) begin
      pkt_parity_d = pkt_data;
    end else if (clear) begin
      pkt_parity_d = '0;
    end
  end

  // Compare only on the first cycle parity_done is seen high, so err then
  // holds through DECODE_ADDRESS until a new header is captured.
  always_comb begin
    err_d = err_q;
    if (err_clear) begin
      err_d = 1'b0;
    end else if (parity_done && !done_seen_q) begin
      err_d = (int_parity_q != pkt_parity_q);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      int_parity_q <= '0;
      pkt_parity_q <= '0;
      done_seen_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      int_parity_q <= int_parity_d;
      pkt_parity_q <= pkt_parity_d;
      done_seen_q  <= parity_done;
      err_q        <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: rtl/router_reg.sv
// Router datapath register stage: header and full-byte latches, FIFO write data,
// and parity handshake flags returned to the router FSM.
module router_reg
  import router_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input logic         clock,
  input logic         resetn,
  router_reg_if.slave bus
);

  logic [DATA_WIDTH-1:0] hdr_byte_q, hdr_byte_d;
  logic [DATA_WIDTH-1:0] full_byte_q, full_byte_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  low_pkt_valid_q, low_pkt_valid_d;
  logic                  parity_done_q, parity_done_d;
  logic                  hdr_capture;
  logic                  fold_en;
  logic [DATA_WIDTH-1:0] fold_data;
  logic                  err;

  assign hdr_capture = bus.detect_add && bus.pkt_valid && addr_valid(bus.data_in[1:0]);

  always_comb begin
    hdr_byte_d = hdr_byte_q;
    if (hdr_capture) begin
      hdr_byte_d = bus.data_in;
    end
  end

  // A byte arriving while the FIFO is full is parked in full_byte and
  // written out later in LOAD_AFTER_FULL.
  always_comb begin
    dout_d      = dout_q;
    full_byte_d = full_byte_q;
    if (bus.lfd_state) begin
      dout_d = hdr_byte_q;
    end else if (bus.ld_state && !bus.fifo_full) begin
      dout_d = bus.data_in;
    end else if (bus.ld_state) begin
      full_byte_d = bus.data_in;
    end else if (bus.laf_state) begin
      dout_d = full_byte_q;
    end
  end

  always_comb begin
    low_pkt_valid_d = low_pkt_valid_q;
    if (bus.rst_int_reg) begin
      low_pkt_valid_d = 1'b0;
    end else if (bus.ld_state && !bus.pkt_valid) begin
      low_pkt_valid_d = 1'b1;
    end
  end

  always_comb begin
    parity_done_d = parity_done_q;
    if (bus.detect_add) begin
      parity_done_d = 1'b0;
    end else if ((bus.ld_state && !bus.fifo_full && !bus.pkt_valid) ||
                 (bus.laf_state && low_pkt_valid_q && !parity_done_q)) begin
      parity_done_d = 1'b1;
    end
  end

  // The byte parked during FIFO_FULL was already folded in LOAD_DATA, so
  // LOAD_AFTER_FULL never folds.
  assign fold_en   = bus.lfd_state || (bus.ld_state && bus.pkt_valid && !bus.full_state);
  assign fold_data = bus.lfd_state ? hdr_byte_q : bus.data_in;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hdr_byte_q      <= '0;
      full_byte_q     <= '0;
      dout_q          <= '0;
      low_pkt_valid_q <= 1'b0;
      parity_done_q   <= 1'b0;
    end else begin
      hdr_byte_q      <= hdr_byte_d;
      full_byte_q     <= full_byte_d;
      dout_q          <= dout_d;
      low_pkt_valid_q <= low_pkt_valid_d;
      parity_done_q   <= parity_done_d;
    end
  end

  router_parity_acc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity_acc (
    .clock       (clock),
    .resetn      (resetn),
    .clear       (bus.detect_add),
    .fold_en     (fold_en),
    .fold_data   (fold_data),
    .pkt_load    (bus.ld_state && !bus.pkt_valid),
    .pkt_data    (bus.data_in),
    .parity_done (parity_done_q),
    .err_clear   (hdr_capture),
    .err         (err)
  );

  assign bus.dout          = dout_q;
  assign bus.parity_done   = parity_done_q;
  assign bus.low_pkt_valid = low_pkt_valid_q;
  assign bus.err           = err;

endmodule

// File: tb/tb_router_reg.sv
// Packet-level bench for router_reg: the bench plays FSM and source, and checks
// dout, the parity flags and err against a byte-stream/XOR reference.
module tb_router_reg;
  import router_pkg::*;

  localparam int unsigned W = 8;

  logic clock = 1'b0;
  logic resetn;

  always #5 clock = ~clock;

  router_reg_if #(.DATA_WIDTH(W)) bus ();

  router_reg #(
    .DATA_WIDTH (W)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference state: last captured header, current FIFO data, expected err.
  logic [W-1:0] exp_hdr;
  logic [W-1:0] exp_dout;
  logic         exp_err;

  logic [W-1:0] pl [0:63];
  int           pl_len;
  bit   [64:0]  full_mask;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic set_state(input state_e s);
    bus.detect_add  = (s == StDecodeAddress);
    bus.lfd_state   = (s == StLoadFirstData);
    bus.ld_state    = (s == StLoadData);
    bus.full_state  = (s == StFifoFullState);
    bus.laf_state   = (s == StLoadAfterFull);
    bus.rst_int_reg = (s == StCheckParityError);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Header address must be valid; payload comes from pl[0:pl_len-1].
  task automatic send_packet(input logic [W-1:0] hdr, input logic [W-1:0] par);
    logic [W-1:0] calc;
    logic [W-1:0] b;
    logic [W-1:0] nxt;
    bit           last;

    set_state(StDecodeAddress);
    bus.pkt_valid = 1'b1;
    bus.data_in   = hdr;
    bus.fifo_full = 1'b0;
    tick();
    exp_hdr = hdr;
    check_eq("err_clr_on_hdr", bus.err, 1'b0);
    check_eq("pd_clr_on_hdr", bus.parity_done, 1'b0);

    set_state(StLoadFirstData);
    bus.data_in = pl[0];
    tick();
    exp_dout = hdr;
    check_eq("dout_hdr", bus.dout, exp_dout);

    calc = hdr;
    for (int i = 0; i < pl_len; i++) calc = calc ^ pl[i];
    exp_err = (calc != par);

    for (int i = 0; i <= pl_len; i++) begin
      last = (i == pl_len);
      b    = last ? par : pl[i];
      if (i + 1 < pl_len)       nxt = pl[i + 1];
      else if (i + 1 == pl_len) nxt = par;
      else                      nxt = W'($urandom);

      set_state(StLoadData);
      bus.pkt_valid = !last;
      bus.data_in   = b;
      bus.fifo_full = full_mask[i];
      tick();
      check_eq("lpv_in_ld", bus.low_pkt_valid, last);
      if (!full_mask[i]) begin
        exp_dout = b;
        check_eq("dout_ld", bus.dout, exp_dout);
      end else begin
        check_eq("dout_hold_full", bus.dout, exp_dout);
        if (last) check_eq("pd_not_in_ld_full", bus.parity_done, 1'b0);

        set_state(StFifoFullState);
        bus.data_in   = nxt;
        bus.pkt_valid = (i + 1 < pl_len);
        for (int k = $urandom_range(0, 2); k >= 0; k--) begin
          bus.fifo_full = (k != 0);
          tick();
          check_eq("dout_hold_fullst", bus.dout, exp_dout);
        end

        set_state(StLoadAfterFull);
        bus.fifo_full = 1'b0;
        tick();
        exp_dout = b;
        check_eq("dout_laf", bus.dout, exp_dout);
      end
    end

    check_eq("pd_after_parity", bus.parity_done, 1'b1);
    check_eq("lpv_after_parity", bus.low_pkt_valid, 1'b1);

    set_state(StCheckParityError);
    bus.pkt_valid = 1'b0;
    bus.fifo_full = 1'b0;
    bus.data_in   = W'($urandom);
    tick();
    check_eq("err_value", bus.err, exp_err);
    check_eq("lpv_cleared", bus.low_pkt_valid, 1'b0);

    set_state(StWaitTillEmpty);
    tick();
    check_eq("err_hold", bus.err, exp_err);
    check_eq("dout_idle_hold", bus.dout, exp_dout);
  endtask

  // Address-3 header: nothing captured, err retained; a following LFD still
  // replays the previously captured header.
  task automatic bad_addr_probe();
    set_state(StDecodeAddress);
    bus.pkt_valid = 1'b1;
    bus.fifo_full = 1'b0;
    bus.data_in   = {6'($urandom), ADDR_INVALID};
    tick();
    check_eq("err_keep_addr3", bus.err, exp_err);
    set_state(StLoadFirstData);
    tick();
    exp_dout = exp_hdr;
    check_eq("hdr_keep_addr3", bus.dout, exp_dout);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [W-1:0] hdr;
    logic [W-1:0] calc;
    logic [W-1:0] par;
    int           len;

    resetn        = 1'b0;
    set_state(StWaitTillEmpty);
    bus.pkt_valid = 1'b0;
    bus.fifo_full = 1'b0;
    bus.data_in   = '0;
    exp_hdr       = '0;
    exp_dout      = '0;
    exp_err       = 1'b0;
    full_mask     = '0;
    tick();
    tick();
    check_eq("rst_dout", bus.dout, '0);
    check_eq("rst_pd", bus.parity_done, 1'b0);
    check_eq("rst_lpv", bus.low_pkt_valid, 1'b0);
    check_eq("rst_err", bus.err, 1'b0);
    resetn = 1'b1;
    tick();

    // Good packet.
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33; pl_len = 3;
    full_mask = '0;
    send_packet(8'h0D, 8'h0D);

    // Bad parity, then an address-3 header must not clear err.
    send_packet(8'h0D, 8'h00);
    bad_addr_probe();

    // Reset mid-LOAD_DATA with every output non-zero.
    set_state(StLoadData);
    bus.pkt_valid = 1'b1;
    bus.data_in   = 8'hA5;
    tick();
    bus.pkt_valid = 1'b0;
    bus.data_in   = 8'h5A;
    tick();
    check_eq("pre_rst_dout", bus.dout, 8'h5A);
    check_eq("pre_rst_lpv", bus.low_pkt_valid, 1'b1);
    check_eq("pre_rst_pd", bus.parity_done, 1'b1);
    check_eq("pre_rst_err", bus.err, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("async_rst_dout", bus.dout, '0);
    check_eq("async_rst_pd", bus.parity_done, 1'b0);
    check_eq("async_rst_lpv", bus.low_pkt_valid, 1'b0);
    check_eq("async_rst_err", bus.err, 1'b0);
    set_state(StWaitTillEmpty);
    bus.pkt_valid = 1'b0;
    tick();
    resetn   = 1'b1;
    exp_hdr  = '0;
    exp_dout = '0;
    exp_err  = 1'b0;
    set_state(StLoadFirstData);
    tick();
    check_eq("post_rst_hdr_zero", bus.dout, '0);

    // FIFO full while 8'h22 is presented.
    full_mask = '0;
    full_mask[1] = 1'b1;
    send_packet(8'h0D, 8'h0D);

    // Parity byte arrives while the FIFO is full.
    full_mask = '0;
    full_mask[3] = 1'b1;
    send_packet(8'h0D, 8'h0D);

    // Randomized packets.
    for (int p = 0; p < 40; p++) begin
      len    = $urandom_range(1, 8);
      hdr    = {6'(len), 2'($urandom_range(0, 2))};
      pl_len = len;
      calc   = hdr;
      for (int i = 0; i < len; i++) begin
        pl[i] = W'($urandom);
        calc  = calc ^ pl[i];
      end
      par = ($urandom_range(0, 1) == 0) ? calc : W'($urandom);
      full_mask = '0;
      for (int i = 0; i <= len; i++) full_mask[i] = ($urandom_range(0, 3) == 0);
      send_packet(hdr, par);
      if ($urandom_range(0, 4) == 0) bad_addr_probe();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
